vector_serializer: RTL and testbench
====================================

# vector_serializer

Streams a LENGTH-scalar vector out one scalar per handshake, in ascending index order. Accepts a whole vector in parallel on a valid/ready input port and emits scalars on a valid/ready output port with index and last markers. It is the read-side counterpart of the parallel-load vector register and feeds scalar-wide datapaths such as dot-product and back-substitution units.

## Interface
- SCALAR_BITS, 32, bits per scalar
- LENGTH, 5, scalars per vector (≥1)
- INDEX_WIDTH (localparam), max(1, $clog2(LENGTH)), index width
- SIZE_BITS (localparam), LENGTH*SCALAR_BITS, vector width
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector
- in  in  SIZE_BITS  vector; scalar i = in[i*SCALAR_BITS +: SCALAR_BITS]
- out_valid  out  1  scalar valid
- out_ready  in  1  consumer accepts scalar
- out  out  SCALAR_BITS  current scalar; 0 when out_valid=0
- out_index  out  INDEX_WIDTH  index of current scalar
- out_last  out  1  out_valid && out_index==LENGTH-1
- busy  out  1  a vector is being streamed or held

## Operation
- Input handshake: in_valid && in_ready at posedge. Output handshake: out_valid && out_ready at posedge.
- FSM (state enum): S_IDLE → S_STREAM on input handshake (vector captured into main buffer, index←0). S_STREAM: each output handshake increments index; handshake with index==LENGTH-1 → S_IDLE (or reload, see Configuration).
- in_ready = (state==S_IDLE) in base build; out_valid = (state==S_STREAM).
- Output stall: while out_valid && !out_ready, out, out_index, out_last hold stable.
- in_valid while in_ready=0 is ignored (not captured); source must hold.
- LENGTH=1: every scalar has out_last=1; index stays 0.
- Reset (any time, including mid-stream): state S_IDLE, index 0, any held vector discarded; outputs: in_ready=1, out_valid=0, out=0, out_index=0, out_last=0, busy=0. Buffer contents need no reset.

## Timing
- Latency: input handshake at edge N → out_valid=1, out_index=0 in cycle after N.
- Throughput: one scalar per cycle while out_ready=1; vector takes LENGTH cycles.
- Base build: last output handshake at edge M → in_ready=1 in cycle after M; next vector at edge M+1 earliest gives out_valid at cycle after M+1 (one-cycle bubble between vectors).
- No combinational path from in_valid to out_*, or from out_ready to in_ready in base build.

## Configuration
- VECTOR_SERIALIZER_PREFETCH_EN defined: adds a one-vector hold buffer. in_ready = !hold_full. Input handshake in S_IDLE loads main directly; in S_STREAM loads hold, unless it coincides with the last output handshake and hold is empty, then loads main directly. Last output handshake with hold full moves hold→main, index←0, out_valid stays 1: zero bubbles between vectors. busy = S_STREAM || hold_full.
- Undefined: no hold buffer, behaviour as in Operation/Timing.

## Structure
- Shared package vector_pkg: serializer_state_t {S_IDLE, S_STREAM}; helper function for INDEX_WIDTH (max(1,$clog2)).
- Main buffer: instantiate existing vector_reg (load, read_index slice read; slice write tied off). Hold buffer (prefetch) is a plain register in this module.

## Test plan
- SCALAR_BITS=32, LENGTH=5; load {5,4,3,2,1} (scalar0=1), out_ready=1 → out 1,2,3,4,5 on 5 consecutive cycles, out_index 0..4, out_last only with 5, in_ready high cycle after.
- Same vector, out_ready toggled 1,0,0,1,... → out/out_index frozen during stalls; exactly 5 handshakes, no duplicates or skips.
- Two back-to-back vectors, out_ready=1: base build → exactly one out_valid=0 cycle between them; with VECTOR_SERIALIZER_PREFETCH_EN → none, second vector's scalar0 follows first's scalar4 directly.
- rst asserted after 2nd scalar (prefetch build, hold full) → next cycle out_valid=0, in_ready=1, busy=0; neither remaining scalars nor held vector ever emitted.
- in_valid held high while streaming (base build) → vector not captured until in_ready=1; captured exactly once.
- LENGTH=1, SCALAR_BITS=8, load 0xA5 → single cycle out=0xA5, out_index=0, out_last=1.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared types and helpers for the vector datapath blocks.
package vector_pkg;

  typedef enum logic [0:0] {
    S_IDLE,
    S_STREAM
  } serializer_state_t;

  // Index width for an n-entry vector; a 1-entry vector still needs a 1-bit index.
  function automatic int unsigned index_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vector_reg.sv
// Parallel-load vector register with single-scalar write and indexed scalar read.
module vector_reg
  import vector_pkg::*;
#(
  parameter int unsigned SCALAR_BITS = 32,
  parameter int unsigned LENGTH      = 5,
  localparam int unsigned INDEX_WIDTH = index_width(LENGTH),
  localparam int unsigned SIZE_BITS   = LENGTH * SCALAR_BITS
) (
  input  logic                   clk,
  input  logic                   load,
  input  logic [SIZE_BITS-1:0]   load_data,
  input  logic                   write_en,
  input  logic [INDEX_WIDTH-1:0] write_index,
  input  logic [SCALAR_BITS-1:0] write_data,
  input  logic [INDEX_WIDTH-1:0] read_index,
  output logic [SCALAR_BITS-1:0] read_data
);

  logic [SCALAR_BITS-1:0] r_mem [LENGTH];

  // Contents are data-only and deliberately not reset.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int unsigned i = 0; i < LENGTH; i++) begin
        r_mem[i] <= load_data[i*SCALAR_BITS +: SCALAR_BITS];
      end
    end else if (write_en) begin
      for (int unsigned i = 0; i < LENGTH; i++) begin
        if (write_index == INDEX_WIDTH'(i)) begin
          r_mem[i] <= write_data;
        end
      end
    end
  end

  // Explicit mux keeps out-of-range indices (non power-of-two LENGTH) well defined.
  always_comb begin
    read_data = '0;
    for (int unsigned i = 0; i < LENGTH; i++) begin
      if (read_index == INDEX_WIDTH'(i)) begin
        read_data = r_mem[i];
      end
    end
  end

endmodule

// File: rtl/vector_serializer.sv
// Streams a parallel-loaded vector out one scalar per valid/ready handshake.
// Define VECTOR_SERIALIZER_PREFETCH_EN to add a one-vector hold buffer (no inter-vector bubble).
module vector_serializer
  import vector_pkg::*;
#(
  parameter int unsigned SCALAR_BITS = 32,
  parameter int unsigned LENGTH      = 5,
  localparam int unsigned INDEX_WIDTH = index_width(LENGTH),
  localparam int unsigned SIZE_BITS   = LENGTH * SCALAR_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SIZE_BITS-1:0]   in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SCALAR_BITS-1:0] out,
  output logic [INDEX_WIDTH-1:0] out_index,
  output logic                   out_last,
  output logic                   busy
);

  localparam logic [INDEX_WIDTH-1:0] LastIndex = INDEX_WIDTH'(LENGTH - 1);

  serializer_state_t      r_state;
  serializer_state_t      w_state_next;
  logic [INDEX_WIDTH-1:0] r_index;
  logic [INDEX_WIDTH-1:0] w_index_next;
  logic                   w_in_hs;
  logic                   w_out_hs;
  logic                   w_at_last;
  logic                   w_load;
  logic [SIZE_BITS-1:0]   w_load_data;
  logic [SCALAR_BITS-1:0] w_read_data;

`ifdef VECTOR_SERIALIZER_PREFETCH_EN
  logic [SIZE_BITS-1:0]   r_hold;
  logic                   r_hold_full;
  logic                   w_hold_full_next;
  logic                   w_hold_load;
`endif

  assign w_in_hs   = in_valid && in_ready;
  assign w_out_hs  = out_valid && out_ready;
  assign w_at_last = (r_index == LastIndex);

  always_comb begin
    w_state_next = r_state;
    w_index_next = r_index;
    w_load       = 1'b0;
    w_load_data  = in;
`ifdef VECTOR_SERIALIZER_PREFETCH_EN
    w_hold_load      = 1'b0;
    w_hold_full_next = r_hold_full;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_in_hs) begin
          w_state_next = S_STREAM;
          w_index_next = '0;
          w_load       = 1'b1;
        end
      end
      S_STREAM: begin
        if (w_out_hs && w_at_last) begin
          w_index_next = '0;
`ifdef VECTOR_SERIALIZER_PREFETCH_EN
          if (r_hold_full) begin
            w_load           = 1'b1;
            w_load_data      = r_hold;
            w_hold_full_next = 1'b0;
          end else if (w_in_hs) begin
            // Hold empty and a vector arrives on the final beat: bypass straight to main.
            w_load = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
`else
          w_state_next = S_IDLE;
`endif
        end else begin
          if (w_out_hs) begin
            w_index_next = r_index + 1'b1;
          end
`ifdef VECTOR_SERIALIZER_PREFETCH_EN
          if (w_in_hs) begin
            w_hold_load      = 1'b1;
            w_hold_full_next = 1'b1;
          end
`endif
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_index_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_index <= '0;
    end else begin
      r_state <= w_state_next;
      r_index <= w_index_next;
    end
  end

`ifdef VECTOR_SERIALIZER_PREFETCH_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_full <= 1'b0;
    end else begin
      r_hold_full <= w_hold_full_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hold_load) begin
      r_hold <= in;
    end
  end
`endif

  vector_reg #(
    .SCALAR_BITS(SCALAR_BITS),
    .LENGTH     (LENGTH)
  ) u_main (
    .clk        (clk),
    .load       (w_load),
    .load_data  (w_load_data),
    .write_en   (1'b0),
    .write_index('0),
    .write_data ('0),
    .read_index (r_index),
    .read_data  (w_read_data)
  );

  assign out_valid = (r_state == S_STREAM);
  assign out       = out_valid ? w_read_data : '0;
  assign out_index = r_index;
  assign out_last  = out_valid && w_at_last;

`ifdef VECTOR_SERIALIZER_PREFETCH_EN
  assign in_ready = !r_hold_full;
  assign busy     = (r_state == S_STREAM) || r_hold_full;
`else
  assign in_ready = (r_state == S_IDLE);
  assign busy     = (r_state == S_STREAM);
`endif

endmodule

// File: tb/tb_vector_serializer.sv
// Self-checking bench for vector_serializer (LENGTH=5 x 32b and LENGTH=1 x 8b instances).
module tb_vector_serializer;

  localparam int LEN = 5;
  localparam int SB  = 32;
`ifdef VECTOR_SERIALIZER_PREFETCH_EN
  localparam bit Prefetch = 1'b1;
`else
  localparam bit Prefetch = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [LEN*SB-1:0] vin;
  logic [SB-1:0]     vout;
  logic [2:0]        vidx;

  logic              in_valid1, in_ready1, out_valid1, out_ready1, out_last1, busy1;
  logic [7:0]        vin1, vout1;
  logic [0:0]        vidx1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vector_serializer #(.SCALAR_BITS(SB), .LENGTH(LEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(vin),
    .out_valid(out_valid), .out_ready(out_ready), .out(vout), .out_index(vidx),
    .out_last(out_last), .busy(busy)
  );

  vector_serializer #(.SCALAR_BITS(8), .LENGTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in(vin1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out(vout1), .out_index(vidx1),
    .out_last(out_last1), .busy(busy1)
  );

  function automatic logic [LEN*SB-1:0] rand_vec();
    logic [LEN*SB-1:0] v;
    for (int i = 0; i < LEN; i++) v[i*SB +: SB] = $urandom;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; vin = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; vin1 = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (vout !== '0) begin n_err++; $display("FAIL reset_out got %0h want 0", vout); end
    n_cmp++; if (vidx !== 3'd0) begin n_err++; $display("FAIL reset_index got %0d want 0", vidx); end
    n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_last got %b want 0", out_last); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || busy1 !== 1'b0) begin
      n_err++; $display("FAIL reset_len1 got rdy=%b vld=%b busy=%b want 1/0/0", in_ready1, out_valid1, busy1);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    @(negedge clk);
    for (int i = 0; i < LEN; i++) vin[i*SB +: SB] = 32'(i + 1);
    in_valid = 1'b1; out_ready = 1'b1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_idle_ready got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < LEN; k++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid[%0d] got %b want 1", k, out_valid); end
      n_cmp++; if (vout !== 32'(k + 1)) begin n_err++; $display("FAIL basic_out[%0d] got %0d want %0d", k, vout, k + 1); end
      n_cmp++; if (vidx !== 3'(k)) begin n_err++; $display("FAIL basic_index[%0d] got %0d want %0d", k, vidx, k); end
      n_cmp++; if (out_last !== (k == LEN - 1)) begin n_err++; $display("FAIL basic_last[%0d] got %b", k, out_last); end
      n_cmp++; if (in_ready !== Prefetch) begin n_err++; $display("FAIL basic_busy_ready[%0d] got %b want %b", k, in_ready, Prefetch); end
      @(negedge clk);
    end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready_after got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_after got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after got %b want 0", busy); end
  endtask

  task automatic test_stall();
    int pat [12] = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 1};
    int k = 0;
    logic prev_stall = 1'b0;
    logic [SB-1:0] prev_out = '0;
    logic [2:0] prev_idx = '0;
    for (int i = 0; i < LEN; i++) vin[i*SB +: SB] = 32'(i + 1);
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 40 && k < LEN; c++) begin
      out_ready = (c < 12) ? pat[c][0] : 1'b1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d] got %b want 1", c, out_valid); end
      n_cmp++; if (vout !== 32'(k + 1) || vidx !== 3'(k)) begin
        n_err++; $display("FAIL stall_data[%0d] got %0d@%0d want %0d@%0d", c, vout, vidx, k + 1, k);
      end
      if (prev_stall) begin
        n_cmp++; if (vout !== prev_out || vidx !== prev_idx) begin
          n_err++; $display("FAIL stall_hold[%0d] got %0h@%0d want %0h@%0d", c, vout, vidx, prev_out, prev_idx);
        end
      end
      prev_stall = out_valid && !out_ready; prev_out = vout; prev_idx = vidx;
      if (out_valid && out_ready) k++;
      @(negedge clk);
    end
    n_cmp++; if (k != LEN) begin n_err++; $display("FAIL stall_count got %0d want %0d", k, LEN); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_no_dup got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [LEN*SB-1:0] va, vb;
    logic [SB-1:0] exp [2*LEN];
    int sent = 0, n = 0, bubbles = 0;
    va = rand_vec(); vb = rand_vec();
    for (int i = 0; i < LEN; i++) begin
      exp[i] = va[i*SB +: SB]; exp[LEN + i] = vb[i*SB +: SB];
    end
    out_ready = 1'b1;
    for (int c = 0; c < 40 && n < 2 * LEN; c++) begin
      if (out_valid) begin
        n_cmp++; if (vout !== exp[n] || vidx !== 3'(n % LEN) || out_last !== (n % LEN == LEN - 1)) begin
          n_err++; $display("FAIL b2b_data[%0d] got %0h@%0d last=%b want %0h@%0d", n, vout, vidx, out_last, exp[n], n % LEN);
        end
        n++;
      end else if (n > 0) begin
        bubbles++;
      end
      if (sent < 2) begin
        vin = (sent == 0) ? va : vb; in_valid = 1'b1;
        if (in_ready) sent++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_cmp++; if (n != 2 * LEN) begin n_err++; $display("FAIL b2b_count got %0d want %0d", n, 2 * LEN); end
    n_cmp++; if (bubbles != (Prefetch ? 0 : 1)) begin
      n_err++; $display("FAIL b2b_bubbles got %0d want %0d", bubbles, Prefetch ? 0 : 1);
    end
    repeat (3) begin
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_once got %b want 0", out_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [LEN*SB-1:0] va, vb;
    va = rand_vec(); vb = rand_vec();
    vin = va; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (vout !== va[SB-1:0]) begin n_err++; $display("FAIL rmid_s0 got %0h want %0h", vout, va[SB-1:0]); end
    vin = vb;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (vout !== va[2*SB-1:SB]) begin n_err++; $display("FAIL rmid_s1 got %0h want %0h", vout, va[2*SB-1:SB]); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy got %b want 1", busy); end
    @(negedge clk);
    n_cmp++; if (vidx !== 3'd2) begin n_err++; $display("FAIL rmid_idx got %0d want 2", vidx); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL rmid_after got vld=%b rdy=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
    end
    repeat (12) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_discard got %b want 0 (out=%0h)", out_valid, vout); end
    end
  endtask

  task automatic test_random();
    logic [SB-1:0] q [$];
    int qi [$];
    logic drop = 1'b0, prev_stall = 1'b0, drain;
    logic [SB-1:0] prev_out = '0;
    logic [2:0] prev_idx = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < 700; c++) begin
      drain = (c >= 400);
      if (drain && q.size() == 0 && !in_valid && !out_valid) break;
      if (drop) in_valid = 1'b0;
      drop = 1'b0;
      if (out_valid) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL rand_unexpected[%0d] got %0h@%0d want none", c, vout, vidx);
        end else begin
          n_cmp++; if (vout !== q[0] || vidx !== 3'(qi[0]) || out_last !== (qi[0] == LEN - 1)) begin
            n_err++; $display("FAIL rand_data[%0d] got %0h@%0d last=%b want %0h@%0d", c, vout, vidx, out_last, q[0], qi[0]);
          end
        end
      end else begin
        n_cmp++; if (vout !== '0 || out_last !== 1'b0) begin n_err++; $display("FAIL rand_idle_out[%0d] got %0h want 0", c, vout); end
      end
      if (prev_stall) begin
        n_cmp++; if (vout !== prev_out || vidx !== prev_idx) begin
          n_err++; $display("FAIL rand_hold[%0d] got %0h@%0d want %0h@%0d", c, vout, vidx, prev_out, prev_idx);
        end
      end
      out_ready = drain ? 1'b1 : ($urandom_range(3) != 0);
      if (out_valid && out_ready && q.size() > 0) begin void'(q.pop_front()); void'(qi.pop_front()); end
      prev_stall = out_valid && !out_ready; prev_out = vout; prev_idx = vidx;
      if (!in_valid && !drain && $urandom_range(1) == 1) begin vin = rand_vec(); in_valid = 1'b1; end
      if (in_valid && in_ready) begin
        for (int i = 0; i < LEN; i++) begin q.push_back(vin[i*SB +: SB]); qi.push_back(i); end
        drop = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL rand_drain got %0d left want 0", q.size()); end
  endtask

  task automatic test_length1();
    logic [7:0] pend = '0;
    logic drop = 1'b0;
    int got = 0, want = 0;
    vin1 = 8'hA5; in_valid1 = 1'b1; out_ready1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    n_cmp++; if (out_valid1 !== 1'b1 || vout1 !== 8'hA5 || vidx1 !== 1'b0 || out_last1 !== 1'b1) begin
      n_err++; $display("FAIL len1_single got vld=%b out=%0h idx=%0d last=%b want 1/a5/0/1", out_valid1, vout1, vidx1, out_last1);
    end
    @(negedge clk);
    n_cmp++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL len1_done got %b want 0", out_valid1); end
    for (int c = 0; c < 60; c++) begin
      if (drop) in_valid1 = 1'b0;
      drop = 1'b0;
      if (out_valid1) begin
        n_cmp++; if (out_last1 !== 1'b1 || vidx1 !== 1'b0 || vout1 !== pend) begin
          n_err++; $display("FAIL len1_rand[%0d] got %0h idx=%0d last=%b want %0h/0/1", c, vout1, vidx1, out_last1, pend);
        end
      end
      out_ready1 = (c >= 50) ? 1'b1 : 1'(($urandom_range(1)));
      if (out_valid1 && out_ready1) got++;
      if (!in_valid1 && c < 45 && !busy1) begin vin1 = 8'($urandom); in_valid1 = 1'b1; end
      if (in_valid1 && in_ready1) begin pend = vin1; want++; drop = 1'b1; end
      @(negedge clk);
    end
    n_cmp++; if (got != want) begin n_err++; $display("FAIL len1_count got %0d want %0d", got, want); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_length1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
